mul8s_rr_share: RTL
===================

Name: mul8s_rr_share

Overview:
- Shares one exact 8-bit signed multiplier core among NREQ requesters.
- Arbitration is round-robin.
- The datapath is a 2-stage pipeline: operand register, combinational multiply, result register. Both stages use valid/ready backpressure.
- Each response carries the winning requester's ID. Sits between DSP lanes and the single mul8s core instance to save area and power.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, $clog2(NREQ), width of the requester ID.
- CNTW, 16, width of the completed-operation counter.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  synchronous active-low reset.
- req_valid  in  NREQ  per-requester operand valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high per cycle.
- req_a  in  NREQ*8  packed signed operand A; requester i uses bits [8i+7:8i].
- req_b  in  NREQ*8  packed signed operand B, same packing.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts the result.
- rsp_id  out  IDW  index of the requester that owns rsp_o.
- rsp_o  out  16  signed two's-complement product A*B.
- busy  out  1  high when either pipeline stage holds valid data.
- op_count  out  CNTW  count of completed responses; saturates at all-ones.

Behaviour:
- Reset (reset_n=0 at a clock edge), taking priority over all other activity including mid-transfer:
  - s1_valid=0, s2_valid=0, rr_ptr=0, op_count=0.
  - rsp_valid=0, rsp_id=0, rsp_o=0, busy=0.
  - req_ready is 0 while reset_n=0.
  - In-flight operations are discarded with no response.
- Stage 1 (operand register): s1_valid, s1_a, s1_b, s1_id.
- Stage 2 (result register): s2_valid, s2_o, s2_id. The outputs are driven directly from it: rsp_valid=s2_valid, rsp_o=s2_o, rsp_id=s2_id.
- Advance rules:
  - s2_free = !s2_valid | rsp_ready.
  - s1_adv = s1_valid & s2_free. On s1_adv, s2 loads mul(s1_a,s1_b) and s1_id, and s2_valid is set.
  - If s2 is consumed and s1_valid=0, s2_valid is cleared.
  - s1_free = !s1_valid | s1_adv.
- Arbitration (combinational):
  - The winner is the first i with req_valid[i]=1, searching from rr_ptr upward and wrapping modulo NREQ.
  - req_ready[winner] = s1_free & reset_n. All other req_ready bits are 0.
- On accept (req_valid[w] & req_ready[w]):
  - s1 loads req_a[w], req_b[w], w, and s1_valid is set.
  - rr_ptr becomes (w+1) mod NREQ.
- With no accept: rr_ptr holds and s1 clears when it advances.
- Latency: accept at edge t gives rsp_valid=1 after edge t+1, i.e. 2 cycles from request to response with no backpressure. Throughput is 1 op/cycle sustained.
- Backpressure:
  - rsp_ready=0 holds s2 stable: rsp_o and rsp_id must not change while rsp_valid=1 and rsp_ready=0.
  - s1 fills, then all req_ready go 0. Nothing is lost or duplicated.
- Simultaneous events:
  - Same-cycle s2 drain, s1 advance and new accept are all legal, so the pipeline flows.
  - Multiple valid requesters: exactly one wins. Losers keep req_valid asserted and their operands stable (requester obligation).
- A requester may not withdraw req_valid before acceptance. The bench flags this as a protocol error; the RTL does not need to detect it.
- Fairness: with all NREQ requesting continuously, each is granted once every NREQ accepts.
- op_count increments on rsp_valid & rsp_ready. At 2^CNTW-1 it holds.
- busy = s1_valid | s2_valid.
- Arithmetic: full 16-bit signed product with no truncation. -128*-128 = +16384 (0x4000).

Decomposition:
- Package mul8s_share_pkg: constant MUL_W=8, constant PROD_W=16, and a typedef for the s1 payload struct {a, b, id}.
- One sub-module: the team's existing exact 8-bit signed array multiplier (mul8s_1KV6). It is instantiated once between s1 and s2; its unused clock port is tied to clock.
- The round-robin picker stays inline as a function.

Test Plan:
- Single request: requester 2 sends A=0x7F (127), B=0x80 (-128) with rsp_ready=1. Required: req_ready[2] in the same cycle; 2 cycles later rsp_valid=1, rsp_o=0xC080, rsp_id=2; op_count=1.
- Corners via requester 0:
  - A=0x80, B=0x80 -> rsp_o=0x4000.
  - A=0xFF, B=0x01 -> rsp_o=0xFFFF.
  - A=0x00, B=0x80 -> rsp_o=0x0000.
- Round-robin: all 4 requesters hold valid with operands (i+1)*3 -> grants in order 0,1,2,3,0. Responses are rsp_id 0,1,2,3 with products 9, 36, 81, 144, and one response per cycle in steady state.
- Backpressure: stream 5 ops from requester 1 with rsp_ready=0 for 4 cycles.
  - During the stall: after 2 accepts, req_ready=0 and rsp_o is stable.
  - After release: all 5 results arrive in order, none dropped or duplicated.
- Reset mid-flight: reset_n=0 for 1 cycle with s1 and s2 both valid -> next cycle rsp_valid=0, busy=0, op_count=0, rr_ptr=0. The first post-reset request gets its correct product.
- Saturation: force 65536 completions (or CNTW=4 build with 20 ops) -> op_count holds at all-ones.

Source files
------------

// File: rtl/mul8s_share_pkg.sv
// Shared constants and the operand-stage payload type for the shared signed multiplier.
package mul8s_share_pkg;

  localparam int MUL_W   = 8;
  localparam int PROD_W  = 16;
  // The ID field is sized for the largest legal requester count (8).
  localparam int ID_MAXW = 3;

  typedef struct packed {
    logic [MUL_W-1:0]   a;
    logic [MUL_W-1:0]   b;
    logic [ID_MAXW-1:0] id;
  } s1_payload_t;

endpackage

// File: rtl/mul8s_1KV6.sv
// Exact 8x8 signed array multiplier producing a full 16-bit two's-complement product.
module mul8s_1KV6
  import mul8s_share_pkg::*;
(
  input  logic              clk_unused,
  input  logic [MUL_W-1:0]  a,
  input  logic [MUL_W-1:0]  b,
  output logic [PROD_W-1:0] o
);

  logic [PROD_W-1:0] a_ext_s;
  logic [PROD_W-1:0] acc_s;

  // Shift-add rows; the top bit of b carries negative weight, so its row is subtracted.
  always_comb begin
    a_ext_s = {{(PROD_W-MUL_W){a[MUL_W-1]}}, a};
    acc_s   = '0;
    for (int i = 0; i < MUL_W; i++) begin
      if (b[i]) begin
        if (i == MUL_W-1) begin
          acc_s = acc_s - (a_ext_s << i);
        end else begin
          acc_s = acc_s + (a_ext_s << i);
        end
      end else begin
        acc_s = acc_s;
      end
    end
    o = acc_s;
  end

endmodule

// File: rtl/mul8s_rr_share.sv
// Round-robin sharing of one mul8s core among NREQ requesters through a
// 2-stage valid/ready pipeline (operand register, result register).
module mul8s_rr_share
  import mul8s_share_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ),
  parameter int CNTW = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*MUL_W-1:0] req_a,
  input  logic [NREQ*MUL_W-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [PROD_W-1:0]     rsp_o,
  output logic                  busy,
  output logic [CNTW-1:0]       op_count
);

  function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] vld,
                                             input logic [IDW-1:0]  ptr);
    logic [IDW-1:0] win;
    logic           found;
    int             idx;
    win   = ptr;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && vld[IDW'(idx)]) begin
        win   = IDW'(idx);
        found = 1'b1;
      end else begin
        win   = win;
        found = found;
      end
    end
    return win;
  endfunction

  logic [MUL_W-1:0]  a_arr_s [NREQ];
  logic [MUL_W-1:0]  b_arr_s [NREQ];
  s1_payload_t       s1_r;
  logic              s1_valid_r;
  logic              s2_valid_r;
  logic [PROD_W-1:0] s2_o_r;
  logic [IDW-1:0]    s2_id_r;
  logic [IDW-1:0]    rr_ptr_r;
  logic [CNTW-1:0]   op_count_r;
  logic [IDW-1:0]    winner_s;
  logic [IDW-1:0]    ptr_next_s;
  logic [PROD_W-1:0] mul_o_s;
  logic              s2_free_s;
  logic              s1_adv_s;
  logic              s1_free_s;
  logic              accept_s;
  logic              id_hi_unused_s;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign a_arr_s[g] = req_a[g*MUL_W +: MUL_W];
    assign b_arr_s[g] = req_b[g*MUL_W +: MUL_W];
  end

  assign s2_free_s  = !s2_valid_r || rsp_ready;
  assign s1_adv_s   = s1_valid_r && s2_free_s;
  assign s1_free_s  = !s1_valid_r || s1_adv_s;
  assign winner_s   = rr_pick(req_valid, rr_ptr_r);
  assign accept_s   = |(req_valid & req_ready);
  assign ptr_next_s = (winner_s == IDW'(NREQ-1)) ? '0 : winner_s + IDW'(1);
  assign id_hi_unused_s = ^s1_r.id;

  // Grant goes only to the round-robin winner, and only when stage 1 can take it.
  always_comb begin
    req_ready = '0;
    if ((|req_valid) && s1_free_s && reset_n) begin
      req_ready[winner_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  mul8s_1KV6 u_mul (
    .clk_unused (clock),
    .a          (s1_r.a),
    .b          (s1_r.b),
    .o          (mul_o_s)
  );

  // Pipeline stages, arbitration pointer and saturating completion counter.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s1_valid_r <= 1'b0;
      s1_r       <= '0;
      s2_valid_r <= 1'b0;
      s2_o_r     <= '0;
      s2_id_r    <= '0;
      rr_ptr_r   <= '0;
      op_count_r <= '0;
    end else begin
      if (accept_s) begin
        s1_valid_r <= 1'b1;
        s1_r       <= '{a: a_arr_s[winner_s], b: b_arr_s[winner_s], id: ID_MAXW'(winner_s)};
        rr_ptr_r   <= ptr_next_s;
      end else if (s1_adv_s) begin
        s1_valid_r <= 1'b0;
      end
      if (s1_adv_s) begin
        s2_valid_r <= 1'b1;
        s2_o_r     <= mul_o_s;
        s2_id_r    <= s1_r.id[IDW-1:0];
      end else if (rsp_ready) begin
        s2_valid_r <= 1'b0;
      end
      if (s2_valid_r && rsp_ready && (op_count_r != '1)) begin
        op_count_r <= op_count_r + CNTW'(1);
      end
    end
  end

  assign rsp_valid = s2_valid_r;
  assign rsp_o     = s2_o_r;
  assign rsp_id    = s2_id_r;
  assign busy      = s1_valid_r || s2_valid_r;
  assign op_count  = op_count_r;

endmodule
